mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_pkg.sv | 24 ++
 rtl/mem_block_array.sv | 33 +++
 rtl/mem_responder.sv | 137 +++++++++++++
 tb/tb_mem_responder.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and default sizing for the memory responder slice.
package mem_pkg;

  localparam int DEFAULT_ADDR_WIDTH      = 32;
  localparam int DEFAULT_WORD_SIZE       = 32;
  localparam int DEFAULT_WORDS_PER_BLOCK = 4;
  localparam int DEFAULT_LATENCY         = 4;
  localparam int DEFAULT_MEM_BLOCKS      = 1024;

  // Responder transaction state.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RD_RESP = 2'd2,
    WR_WAIT = 2'd3
  } mem_state_t;

  // Bits needed for a down-counter that is loaded with latency-1 and must
  // also represent the full latency value.
  function automatic int cnt_width(input int latency);
    return (latency < 1) ? 1 : $clog2(latency + 1);
  endfunction

endpackage

// File: rtl/mem_block_array.sv
// Single-port synchronous block store: one access per cycle, write has
// priority over read, read data is registered and held until the next read.
module mem_block_array #(
  parameter int DEPTH = 1024,
  parameter int WIDTH = 128,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rd_en_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // Storage write or registered read through the one shared port.
  // NOTE: no reset here -- array contents and the read register are data,
  // not control, and a reset would prevent mapping onto RAM macros. Sequential
  // state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[idx_i] <= wdata_i;
    end else if (rd_en_i) begin
      rdata_q <= mem_q[idx_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency backing memory for a cache: accepts block refills and
// writebacks from IDLE, counts out the access latency, and presents refill
// data with a valid/ready handshake.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_WIDTH      = DEFAULT_ADDR_WIDTH,
  parameter int WORD_SIZE       = DEFAULT_WORD_SIZE,
  parameter int WORDS_PER_BLOCK = DEFAULT_WORDS_PER_BLOCK,
  parameter int BLOCK_SIZE      = WORD_SIZE * WORDS_PER_BLOCK,
  parameter int MEM_BLOCKS      = DEFAULT_MEM_BLOCKS,
  parameter int LATENCY         = DEFAULT_LATENCY
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_en_mem,
  input  logic                  write_en_mem,
  input  logic                  valid_cache,
  input  logic                  ready_cache,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [BLOCK_SIZE-1:0] dirty_block_in,
  output logic                  ready_mem,
  output logic                  valid_mem,
  output logic [BLOCK_SIZE-1:0] data_out_mem,
  output logic                  busy
);

  localparam int OFFSET_WIDTH = $clog2(WORDS_PER_BLOCK);
  localparam int IDX_W        = $clog2(MEM_BLOCKS);
  localparam int CNT_W        = cnt_width(LATENCY);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

  mem_state_t              state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [IDX_W-1:0]        idx_q;
  logic [BLOCK_SIZE-1:0]   wdata_q;
  logic                    valid_q;
  logic [BLOCK_SIZE-1:0]   dout_q;

  logic [IDX_W-1:0]        req_idx;
  logic                    wr_accept;
  logic                    cnt_zero;
  logic                    mem_we;
  logic                    mem_re;
  logic [BLOCK_SIZE-1:0]   mem_rdata;
  logic                    unused_addr;

  // Word offset and address bits above the block index do not select storage.
  assign req_idx     = addr[OFFSET_WIDTH +: IDX_W];
  assign unused_addr = ^addr;

  // A writeback needs its data qualified; an unqualified write request is
  // dropped so a pending refill in the same cycle can still be taken.
  assign wr_accept = write_en_mem && valid_cache;
  assign cnt_zero  = (cnt_q == '0);

  // Storage is touched exactly once per transaction, on the last wait cycle.
  // Both strobes decode from registered state, so an asserted reset kills a
  // pending writeback before it reaches the array.
  assign mem_we = (state_q == WR_WAIT) && cnt_zero;
  assign mem_re = (state_q == RD_WAIT) && cnt_zero;

  mem_block_array #(
    .DEPTH (MEM_BLOCKS),
    .WIDTH (BLOCK_SIZE)
  ) u_array (
    .clk     (clk),
    .rd_en_i (mem_re),
    .wr_en_i (mem_we),
    .idx_i   (idx_q),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  // Transaction FSM with latency counter and registered response outputs.
  // The first RD_RESP cycle captures the array read register, which makes
  // valid_mem rise LATENCY+1 edges after the accept edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wdata_q <= '0;
      valid_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (wr_accept) begin
            idx_q   <= req_idx;
            wdata_q <= dirty_block_in;
            cnt_q   <= CNT_LOAD;
            state_q <= WR_WAIT;
          end else if (read_en_mem) begin
            idx_q   <= req_idx;
            cnt_q   <= CNT_LOAD;
            state_q <= RD_WAIT;
          end
        end
        WR_WAIT: begin
          if (cnt_zero) begin
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RD_WAIT: begin
          if (cnt_zero) begin
            state_q <= RD_RESP;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        RD_RESP: begin
          if (!valid_q) begin
            valid_q <= 1'b1;
            dout_q  <= mem_rdata;
          end else if (ready_cache) begin
            valid_q <= 1'b0;
            dout_q  <= '0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign ready_mem    = (state_q == IDLE);
  assign busy         = (state_q != IDLE);
  assign valid_mem    = valid_q;
  assign data_out_mem = dout_q;

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: default LATENCY=4 instance plus a
// LATENCY=1 instance for back-to-back refills.
module tb_mem_responder;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         rd0, wr0, vc0, rc0;
  logic [31:0]  addr0;
  logic [127:0] din0;
  logic         rm0, vm0, busy0;
  logic [127:0] dout0;

  logic         rd1, wr1, vc1, rc1;
  logic [31:0]  addr1;
  logic [127:0] din1;
  logic         rm1, vm1, busy1;
  logic [127:0] dout1;

  int total = 0;
  int bad   = 0;

  localparam logic [127:0] PAT_A5   = {16{8'hA5}};
  localparam logic [127:0] PAT_5A   = {16{8'h5A}};
  localparam logic [127:0] PAT_DEAD = {4{32'hDEADBEEF}};
  localparam logic [127:0] PAT_L1A  = {16{8'h11}};
  localparam logic [127:0] PAT_L1B  = {8{16'hBEEF}};

  always #5 clk = ~clk;

  mem_responder dut0 (
    .clk            (clk),
    .rst            (rst),
    .read_en_mem    (rd0),
    .write_en_mem   (wr0),
    .valid_cache    (vc0),
    .ready_cache    (rc0),
    .addr           (addr0),
    .dirty_block_in (din0),
    .ready_mem      (rm0),
    .valid_mem      (vm0),
    .data_out_mem   (dout0),
    .busy           (busy0)
  );

  mem_responder #(.LATENCY(1)) dut1 (
    .clk            (clk),
    .rst            (rst),
    .read_en_mem    (rd1),
    .write_en_mem   (wr1),
    .valid_cache    (vc1),
    .ready_cache    (rc1),
    .addr           (addr1),
    .dirty_block_in (din1),
    .ready_mem      (rm1),
    .valid_mem      (vm1),
    .data_out_mem   (dout1),
    .busy           (busy1)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input bit sel, input int idx, input logic [127:0] d);
    if (sel) dut1.u_array.mem_q[idx] = d;
    else     dut0.u_array.mem_q[idx] = d;
  endtask

  // Full refill with ready_cache high; address is scrambled after accept to
  // show the request is latched.
  task automatic refill(input bit sel, input logic [31:0] a, input logic [127:0] exp,
                        input int exp_lat, input string tag);
    int n;
    bit dz;
    if (sel) begin rd1 = 1'b1; addr1 = a; rc1 = 1'b1; end
    else     begin rd0 = 1'b1; addr0 = a; rc0 = 1'b1; end
    tick();
    if (sel) begin rd1 = 1'b0; addr1 = 32'hFFF0; end
    else     begin rd0 = 1'b0; addr0 = 32'hFFF0; end
    check({tag, "_busy"}, sel ? busy1 : busy0, 128'd1);
    check({tag, "_rdy_lo"}, sel ? rm1 : rm0, 128'd0);
    n  = 0;
    dz = 1'b1;
    while (n < 30) begin
      if (sel ? vm1 : vm0) break;
      if ((sel ? dout1 : dout0) != '0) dz = 1'b0;
      tick();
      n++;
    end
    check({tag, "_lat"}, 128'(n), 128'(exp_lat));
    check({tag, "_zero_pre"}, 128'(dz), 128'd1);
    check({tag, "_data"}, sel ? dout1 : dout0, exp);
    tick();
    check({tag, "_vld_off"}, sel ? vm1 : vm0, 128'd0);
    check({tag, "_dat_off"}, sel ? dout1 : dout0, 128'd0);
    check({tag, "_idle"}, sel ? rm1 : rm0, 128'd1);
  endtask

  // Writeback on dut0; reports how many sampled cycles ready_mem stayed low.
  task automatic writeback(input logic [31:0] a, input logic [127:0] d, input string tag);
    int low;
    wr0 = 1'b1; vc0 = 1'b1; addr0 = a; din0 = d;
    tick();
    wr0 = 1'b0; vc0 = 1'b0;
    low = 0;
    while (!rm0 && low < 30) begin
      low++;
      tick();
    end
    check({tag, "_rdy_low"}, 128'(low), 128'd4);
    check({tag, "_busy_end"}, busy0, 128'd0);
  endtask

  initial begin
    int k;
    int n;
    rd0 = 0; wr0 = 0; vc0 = 0; rc0 = 0; addr0 = '0; din0 = '0;
    rd1 = 0; wr1 = 0; vc1 = 0; rc1 = 0; addr1 = '0; din1 = '0;

    preload(1'b0, 5,  PAT_A5);
    preload(1'b0, 16, PAT_5A);
    preload(1'b0, 12, PAT_DEAD);
    preload(1'b1, 1,  PAT_L1A);
    preload(1'b1, 2,  PAT_L1B);

    // Reset values once reset is released.
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("rst_ready", rm0, 128'd1);
    check("rst_busy",  busy0, 128'd0);
    check("rst_valid", vm0, 128'd0);
    check("rst_data",  dout0, 128'd0);

    // Plain refill of index 5, then with high address bits set.
    refill(1'b0, 32'h0000_0014, PAT_A5, 5, "rd5");
    refill(1'b0, 32'hABCD_0014, PAT_A5, 5, "rd5_hi");

    // Writeback then read-after-write.
    writeback(32'h20, 128'h1234, "wb20");
    refill(1'b0, 32'h20, 128'h1234, 5, "raw20");

    // Simultaneous writeback and refill: the write goes first.
    rd0 = 1'b1; wr0 = 1'b1; vc0 = 1'b1; addr0 = 32'h40; din0 = 128'hC0FFEE; rc0 = 1'b1;
    tick();
    wr0 = 1'b0; vc0 = 1'b0;
    check("sim_busy", busy0, 128'd1);
    k = 0;
    while (!rm0 && k < 30) begin
      tick();
      k++;
    end
    check("sim_wr_len", 128'(k), 128'd4);
    tick();
    rd0 = 1'b0;
    n = 0;
    while (!vm0 && n < 30) begin
      tick();
      n++;
    end
    check("sim_rd_lat", 128'(n), 128'd5);
    check("sim_rd_data", dout0, 128'hC0FFEE);
    tick();
    check("sim_vld_off", vm0, 128'd0);

    // Refill with ready_cache low for three valid cycles.
    rd0 = 1'b1; addr0 = 32'h14; rc0 = 1'b0;
    tick();
    rd0 = 1'b0;
    n = 0;
    while (!vm0 && n < 30) begin
      tick();
      n++;
    end
    check("stall_lat", 128'(n), 128'd5);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("stall_vld%0d", i), vm0, 128'd1);
      check($sformatf("stall_dat%0d", i), dout0, PAT_A5);
      if (i < 3) tick();
    end
    rc0 = 1'b1;
    tick();
    check("stall_vld_off", vm0, 128'd0);
    check("stall_dat_off", dout0, 128'd0);
    check("stall_idle", rm0, 128'd1);

    // Reset two cycles into a writeback: no commit, outputs at reset values.
    wr0 = 1'b1; vc0 = 1'b1; addr0 = 32'h30; din0 = 128'h1111;
    tick();
    wr0 = 1'b0; vc0 = 1'b0;
    tick();
    tick();
    check("abort_busy_pre", busy0, 128'd1);
    rst = 1'b1;
    #1;
    check("abort_ready", rm0, 128'd1);
    check("abort_busy",  busy0, 128'd0);
    check("abort_valid", vm0, 128'd0);
    check("abort_data",  dout0, 128'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    refill(1'b0, 32'h30, PAT_DEAD, 5, "abort_rd30");

    // LATENCY=1 instance, back-to-back refills.
    refill(1'b1, 32'h4, PAT_L1A, 2, "l1_a");
    refill(1'b1, 32'h8, PAT_L1B, 2, "l1_b");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
